// File: rtl/flush_sequencer_if.sv
// Fence request and per-target flush handshake bundle.
//   fence_valid  source -> sequencer   fence request, held until accepted
//   fence_ready  sequencer -> source   sequencer can take a fence this cycle
//   fence_mask   source -> sequencer   targets to flush, sampled on accept
//   flush_req    sequencer -> targets  per-target request, held until acked
//   flush_ack    targets -> sequencer  per-target single-cycle acknowledge
// master: the sequencer side. slave: the fence source plus flush targets.
interface flush_sequencer_if #(
    parameter int unsigned NrTargets = 4
);
    logic                 fence_valid;
    logic                 fence_ready;
    logic [NrTargets-1:0] fence_mask;
    logic [NrTargets-1:0] flush_req;
    logic [NrTargets-1:0] flush_ack;

    modport master (
        input  fence_valid,
        input  fence_mask,
        input  flush_ack,
        output fence_ready,
        output flush_req
    );

    modport slave (
        output fence_valid,
        output fence_mask,
        output flush_ack,
        input  fence_ready,
        input  flush_req
    );
endinterface

// File: rtl/flush_sequencer.sv
// Fence/flush sequencer beside commit. Takes one fence with a per-target flush
// mask, flushes the pipeline and redirects the PC, then holds a req/ack
// handshake to each selected flush target until all acknowledge or a timeout
// fires. Exceptions only flush the pipeline and never disturb a sequence.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   fs                 fence request + flush req/ack bundle (master side)
//   ex_valid_i         exception/eret/debug entry: flush pipeline, no set_pc
//   halt_csr_i         WFI halt request from CSR
//   halt_o             halt commit stage (combinational)
//   set_pc_commit_o    PC gen takes commit PC + 4 (combinational, accept cycle)
//   flush_pipe_o       flush IF/ID/EX (combinational)
//   done_o             one-cycle pulse when a sequence finishes
//   timeout_o          sticky: last sequence ended by timeout
module flush_sequencer #(
    parameter int unsigned NrTargets     = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    flush_sequencer_if.master     fs,
    input  logic                  ex_valid_i,
    input  logic                  halt_csr_i,
    output logic                  halt_o,
    output logic                  set_pc_commit_o,
    output logic                  flush_pipe_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    // Counter is kept one bit wide when the timeout is disabled so the
    // declaration stays legal; it is then held at zero.
    localparam int unsigned CntWidth    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned TimeoutLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NrTargets-1:0]  pending_q, pending_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;

    logic                  fence_ready_c;
    logic                  accept_c;
    logic                  set_pc_c;
    logic                  flush_pipe_c;
    logic                  timeout_hit_c;
    logic [NrTargets-1:0]  pending_left_c;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    // Next-state, handshake bookkeeping and combinational pipeline controls.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;
        done_d         = 1'b0;

        // An exception in the same cycle wins over a fence.
        fence_ready_c  = (state_q == IDLE) & ~ex_valid_i;
        accept_c       = fs.fence_valid & fence_ready_c;
        set_pc_c       = accept_c;
        flush_pipe_c   = accept_c | ex_valid_i;

        // Acks on bits that are not pending simply have no effect here.
        pending_left_c = pending_q & ~fs.flush_ack;
        timeout_hit_c  = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutLast));

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    pending_d = fs.fence_mask;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (fs.fence_mask != '0) ? WAIT_ACK : DONE;
                end
            end
            WAIT_ACK: begin
                pending_d = pending_left_c;
                if (TimeoutCycles != 0) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
                if (pending_left_c == '0) begin
                    state_d = DONE;
                end else if (timeout_hit_c) begin
                    // Abandon the stragglers; acks landing this cycle already counted.
                    pending_d = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
    end

    assign fs.fence_ready    = fence_ready_c;
    assign fs.flush_req      = pending_q;
    assign set_pc_commit_o   = set_pc_c;
    assign flush_pipe_o      = flush_pipe_c;
    assign halt_o            = halt_csr_i | (state_q != IDLE);
    assign done_o            = done_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: a per-cycle vector table of inputs and
// hand-computed outputs, plus hand-written ack-ordering and reset sequences.
module tb_flush_sequencer;

    localparam int unsigned NrTargets     = 4;
    localparam int unsigned TimeoutCycles = 8;

    logic clk;
    logic rst_ni;
    logic ex_valid;
    logic halt_csr;
    logic halt;
    logic set_pc_commit;
    logic flush_pipe;
    logic done;
    logic timeout;

    int checks = 0;
    int errors = 0;

    flush_sequencer_if #(.NrTargets(NrTargets)) bus ();

    flush_sequencer #(
        .NrTargets    (NrTargets),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .fs             (bus),
        .ex_valid_i     (ex_valid),
        .halt_csr_i     (halt_csr),
        .halt_o         (halt),
        .set_pc_commit_o(set_pc_commit),
        .flush_pipe_o   (flush_pipe),
        .done_o         (done),
        .timeout_o      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fv;
        logic [3:0] mask;
        logic       ex;
        logic       hcsr;
        logic [3:0] ack;
        logic       e_rdy;
        logic       e_spc;
        logic       e_fp;
        logic       e_halt;
        logic [3:0] e_req;
        logic       e_done;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [3:0] mask, input logic ex, input logic hcsr,
                       input logic [3:0] ack, input logic rdy, input logic spc, input logic fp,
                       input logic hlt, input logic [3:0] req, input logic dn, input logic to);
        vec_t v;
        v.fv = fv; v.mask = mask; v.ex = ex; v.hcsr = hcsr; v.ack = ack;
        v.e_rdy = rdy; v.e_spc = spc; v.e_fp = fp; v.e_halt = hlt;
        v.e_req = req; v.e_done = dn; v.e_to = to;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.fence_valid = 1'b0;
        bus.fence_mask  = '0;
        bus.flush_ack   = '0;
        ex_valid        = 1'b0;
        halt_csr        = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic [3:0] rem;
        logic [3:0] order [4];

        // Columns: fv mask ex hcsr ack | rdy spc fp halt req done to
        // Mask 0101, ack[0] at T+1, ack[2] at T+3.
        add(1, 4'b0101, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0001,  0, 0, 0, 1, 4'b0101, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0100, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0100,  0, 0, 0, 1, 4'b0100, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 0);
        // Exception beats fence in IDLE; fence accepted the next cycle, all acks together.
        add(1, 4'b1111, 1, 0, 4'b0000,  0, 0, 1, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b1111,  0, 0, 0, 1, 4'b1111, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 0);
        // CSR halt passes through in IDLE.
        add(0, 4'b0000, 0, 1, 4'b0000,  1, 0, 0, 1, 4'b0000, 0, 0);
        // Zero mask: pulse at T, done at T+1, no requests.
        add(1, 4'b0000, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 0);
        // Spurious ack[3], exception mid-wait, then all-bits ack.
        add(1, 4'b0001, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b1000,  0, 0, 0, 1, 4'b0001, 0, 0);
        add(0, 4'b0000, 1, 0, 4'b0000,  0, 0, 1, 1, 4'b0001, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b1111,  0, 0, 0, 1, 4'b0001, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 0);
        // Timeout: mask 0011, only ack[0] at T+2, fires at T+8, done at T+9.
        add(1, 4'b0011, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0011, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0001,  0, 0, 0, 1, 4'b0011, 0, 0);
        for (int i = 3; i <= 8; i++) begin
            add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0010, 0, 0);
        end
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 1);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 1);
        // Last ack exactly at cnt==7 does not time out; sticky flag clears after accept.
        add(1, 4'b0001, 0, 0, 4'b0000,  1, 1, 1, 0, 4'b0000, 0, 1);
        for (int i = 1; i <= 7; i++) begin
            add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0001, 0, 0);
        end
        add(0, 4'b0000, 0, 0, 4'b0001,  0, 0, 0, 1, 4'b0001, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  0, 0, 0, 1, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000,  1, 0, 0, 0, 4'b0000, 0, 0);

        rst_ni = 1'b0;
        drive_idle();
        #3;
        chk("rst_flush_req", -1, 32'(bus.flush_req), 32'h0);
        chk("rst_done",      -1, 32'(done),          32'h0);
        chk("rst_timeout",   -1, 32'(timeout),       32'h0);
        chk("rst_halt",      -1, 32'(halt),          32'h0);
        chk("rst_ready",     -1, 32'(bus.fence_ready), 32'h1);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.fence_valid = vecs[i].fv;
            bus.fence_mask  = vecs[i].mask;
            ex_valid        = vecs[i].ex;
            halt_csr        = vecs[i].hcsr;
            bus.flush_ack   = vecs[i].ack;
            @(negedge clk);
            chk("fence_ready", i, 32'(bus.fence_ready), 32'(vecs[i].e_rdy));
            chk("set_pc",      i, 32'(set_pc_commit),   32'(vecs[i].e_spc));
            chk("flush_pipe",  i, 32'(flush_pipe),      32'(vecs[i].e_fp));
            chk("halt",        i, 32'(halt),            32'(vecs[i].e_halt));
            chk("flush_req",   i, 32'(bus.flush_req),   32'(vecs[i].e_req));
            chk("done",        i, 32'(done),            32'(vecs[i].e_done));
            chk("timeout",     i, 32'(timeout),         32'(vecs[i].e_to));
            @(posedge clk);
            #1;
        end
        drive_idle();

        // Acks one per cycle in scrambled order; done expected 5 cycles after accept.
        order[0] = 4'b0100;
        order[1] = 4'b0001;
        order[2] = 4'b1000;
        order[3] = 4'b0010;
        bus.fence_valid = 1'b1;
        bus.fence_mask  = 4'b1111;
        @(posedge clk);
        #1;
        bus.fence_valid = 1'b0;
        bus.fence_mask  = '0;
        cyc = 1;
        rem = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            chk("order_req", 100 + i, 32'(bus.flush_req), 32'(rem));
            bus.flush_ack = order[i];
            rem = rem & ~order[i];
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.flush_ack = '0;
        while (!done && cyc < 25) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("order_done_latency", 104, 32'(cyc), 32'd5);
        chk("order_timeout", 105, 32'(timeout), 32'h0);
        @(posedge clk);
        #1;

        // Asynchronous reset in WAIT_ACK; acks presented during reset are dropped.
        bus.fence_valid = 1'b1;
        bus.fence_mask  = 4'b0011;
        @(posedge clk);
        #1;
        bus.fence_valid = 1'b0;
        bus.fence_mask  = '0;
        chk("rst_mid_req_before", 200, 32'(bus.flush_req), 32'h3);
        #2;
        rst_ni = 1'b0;
        bus.flush_ack = 4'b0011;
        #1;
        chk("rst_mid_req",     201, 32'(bus.flush_req), 32'h0);
        chk("rst_mid_halt",    202, 32'(halt),          32'h0);
        chk("rst_mid_done",    203, 32'(done),          32'h0);
        chk("rst_mid_timeout", 204, 32'(timeout),       32'h0);
        @(posedge clk);
        #1;
        bus.flush_ack = '0;
        #2;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 205, 32'(bus.fence_ready), 32'h1);
        chk("post_rst_req",   206, 32'(bus.flush_req),   32'h0);
        chk("post_rst_halt",  207, 32'(halt),            32'h0);
        @(posedge clk);
        #1;

        // A fresh sequence after reset still works end to end.
        bus.fence_valid = 1'b1;
        bus.fence_mask  = 4'b1000;
        @(posedge clk);
        #1;
        bus.fence_valid = 1'b0;
        bus.fence_mask  = '0;
        chk("post_rst_seq_req", 208, 32'(bus.flush_req), 32'h8);
        bus.flush_ack = 4'b1000;
        @(posedge clk);
        #1;
        bus.flush_ack = '0;
        chk("post_rst_seq_done", 209, 32'(done), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
